seven_seg_scanner: RTL

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It receives the eight per-digit segment patterns produced by the game's display decoder and drives them onto a shared segment bus, one digit at a time. It adds per-frame snapshotting (no tearing), an inter-digit blanking gap (anti-ghosting), 8-level brightness and per-digit blinking (cursor highlight). It sits between the game top level and the board pins.

---
 rtl/seven_seg_scanner.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each frame is eight back-to-back digit slots of DIGIT_CYCLES clocks. Every
// slot opens with BLANK_CYCLES dark cycles (anti-ghosting), then lights the
// digit for W*(brightness+1) cycles, with W = (DIGIT_CYCLES-BLANK_CYCLES)/8.
// Digit patterns, blink mask and brightness are snapshotted once per frame so
// the picture never tears. Digits flagged in the blink mask are hidden on
// alternate runs of BLINK_FRAMES frames.
//
// Parameters:
//   DIGIT_CYCLES  clocks per digit slot
//   BLANK_CYCLES  dark clocks at the start of each slot
//                 (1 <= BLANK_CYCLES < DIGIT_CYCLES, and
//                  DIGIT_CYCLES-BLANK_CYCLES divisible by 8)
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//
// Ports:
//   clk          system clock
//   reset        asynchronous reset, active low
//   enable       1 = scan, 0 = dark with counters cleared
//   d0..d7       digit segment patterns, bit6..bit0 = g..a, 1 = lit
//   blink_mask   bit k = 1 makes digit k blink
//   brightness   0 = dimmest, 7 = full
//   an           digit enables, active low, an[k] drives digit k
//   seg          segment bus, active low
//   frame_start  one-cycle pulse in the first cycle of every frame
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] d0,
    input  logic [6:0] d1,
    input  logic [6:0] d2,
    input  logic [6:0] d3,
    input  logic [6:0] d4,
    input  logic [6:0] d5,
    input  logic [6:0] d6,
    input  logic [6:0] d7,
    input  logic [7:0] blink_mask,
    input  logic [2:0] brightness,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       frame_start
);

    localparam int W  = (DIGIT_CYCLES - BLANK_CYCLES) / 8;
    localparam int SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGIT_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // IDLE: dark, waiting for enable. The first clock edge that sees
    // enable = 1 in IDLE is a frame-start edge and moves to SCAN.
    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [2:0]    digit_q, digit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic [6:0]    dSnap_q [8];
    logic [6:0]    dSnap_d [8];
    logic [7:0]    maskSnap_q, maskSnap_d;
    logic [2:0]    brightSnap_q, brightSnap_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frameStart_q, frameStart_d;

    logic          loadSnap;
    logic          blinkHide;
    logic [31:0]   offsetWide;
    logic [31:0]   litEnd;

    // Next-state logic. The counters describe the position that will be on
    // the pins during the next cycle, and the registered outputs are decoded
    // from that same position, so an/seg/frame_start stay mutually aligned.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        digit_d      = digit_q;
        frame_d      = frame_q;
        phase_d      = phase_q;
        dSnap_d      = dSnap_q;
        maskSnap_d   = maskSnap_q;
        brightSnap_d = brightSnap_q;
        an_d         = 8'hFF;
        seg_d        = 7'h7F;
        frameStart_d = 1'b0;
        loadSnap     = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            slot_d  = '0;
            digit_d = '0;
            frame_d = '0;
            phase_d = 1'b0;
        end else if (state_q == IDLE) begin
            // Restart: blink sequence begins again at frame 0, phase 0.
            state_d      = SCAN;
            slot_d       = '0;
            digit_d      = '0;
            loadSnap     = 1'b1;
            frameStart_d = 1'b1;
        end else if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            if (digit_q == 3'd7) begin
                digit_d      = '0;
                loadSnap     = 1'b1;
                frameStart_d = 1'b1;
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + FW'(1);
                end
            end else begin
                digit_d = digit_q + 3'd1;
            end
        end else begin
            slot_d = slot_q + SW'(1);
        end

        if (loadSnap) begin
            dSnap_d[0]   = d0;
            dSnap_d[1]   = d1;
            dSnap_d[2]   = d2;
            dSnap_d[3]   = d3;
            dSnap_d[4]   = d4;
            dSnap_d[5]   = d5;
            dSnap_d[6]   = d6;
            dSnap_d[7]   = d7;
            maskSnap_d   = blink_mask;
            brightSnap_d = brightness;
        end

        // Lit window: [BLANK, BLANK + W*(brightness+1)) within the slot.
        offsetWide = 32'(slot_d);
        litEnd     = 32'(BLANK_CYCLES) + 32'(W) * (32'(brightSnap_d) + 32'd1);
        blinkHide  = phase_d & maskSnap_d[digit_d];

        if ((state_d == SCAN) && (offsetWide >= 32'(BLANK_CYCLES)) &&
            (offsetWide < litEnd) && !blinkHide) begin
            an_d  = ~(8'd1 << digit_d);
            seg_d = ~dSnap_d[digit_d];
        end
    end

    // State and output registers; reset darkens the display at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            digit_q      <= '0;
            frame_q      <= '0;
            phase_q      <= 1'b0;
            dSnap_q      <= '{default: '0};
            maskSnap_q   <= '0;
            brightSnap_q <= '0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            frameStart_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            digit_q      <= digit_d;
            frame_q      <= frame_d;
            phase_q      <= phase_d;
            dSnap_q      <= dSnap_d;
            maskSnap_q   <= maskSnap_d;
            brightSnap_q <= brightSnap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = frameStart_q;

endmodule
